xip_fill_arbiter: RTL

- Shares one SPI flash line reader between two cache line-fill requesters: requester 0 is the instruction XIP cache, requester 1 is the data/literal cache.
- Sits between the two cache controllers and the flash reader.
- Sequences exactly one 16-byte line fill at a time and arbitrates round-robin.
- Returns completion to the winner, and also to the loser when both requested the same line.

---
 rtl/xip_fill_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/xip_fill_arbiter.sv
// Round-robin arbiter that sequences 16-byte line fills from two caches onto one SPI flash line reader.
// Define XIP_FILL_ARB_TIMEOUT_EN to add a watchdog that aborts a fill when the reader never completes.
module xip_fill_arbiter #(
    parameter int ADDR_W         = 24,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              done0,
    output logic              err0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              done1,
    output logic              err1,
    output logic              fr_rd,
    output logic [ADDR_W-1:0] fr_addr,
    input  logic              fr_done,
    output logic              busy
);
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_BUSY, ST_DONE} state_t;

    state_t            state_q;
    logic              gnt_q;
    logic              rr_last_q;
    logic              fr_rd_q;
    logic              busy_q;
    logic [1:0]        done_q;
    logic [ADDR_W-1:0] fr_addr_q;

    logic [ADDR_W-1:0] line0_d;
    logic [ADDR_W-1:0] line1_d;
    logic [ADDR_W-1:0] win_line_d;
    logic              win_d;
    logic              merge_d;
    logic [1:0]        gnt_mask_d;

`ifdef XIP_FILL_ARB_TIMEOUT_EN
    localparam int               CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_q;
    logic [1:0]       err_q;
`endif

    // Byte offset within a line never reaches the reader or the merge compare.
    logic unused_ok;
    assign unused_ok = &{1'b0, addr0[3:0], addr1[3:0], (TIMEOUT_CYCLES == 0)};

    always_comb begin
        line0_d    = {addr0[ADDR_W-1:4], 4'd0};
        line1_d    = {addr1[ADDR_W-1:4], 4'd0};
        win_d      = (req0 && req1) ? ~rr_last_q : req1;
        win_line_d = win_d ? line1_d : line0_d;
        merge_d    = gnt_q ? (req0 && (line0_d == fr_addr_q))
                           : (req1 && (line1_d == fr_addr_q));
        gnt_mask_d = gnt_q ? 2'b10 : 2'b01;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 1'b0;
            rr_last_q <= 1'b1;
            fr_rd_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 2'b00;
            fr_addr_q <= '0;
`ifdef XIP_FILL_ARB_TIMEOUT_EN
            tmo_cnt_q <= '0;
            err_q     <= 2'b00;
`endif
        end else begin
            fr_rd_q <= 1'b0;
            done_q  <= 2'b00;
`ifdef XIP_FILL_ARB_TIMEOUT_EN
            err_q   <= 2'b00;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        gnt_q     <= win_d;
                        fr_addr_q <= win_line_d;
                        fr_rd_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_BUSY;
`ifdef XIP_FILL_ARB_TIMEOUT_EN
                    tmo_cnt_q <= '0;
`endif
                end
                ST_BUSY: begin
                    // The loser is served too when it is waiting on the very line just read.
                    if (fr_done) begin
                        state_q <= ST_DONE;
                        done_q  <= gnt_mask_d | (merge_d ? ~gnt_mask_d : 2'b00);
                    end
`ifdef XIP_FILL_ARB_TIMEOUT_EN
                    else if (tmo_cnt_q == CNT_LAST) begin
                        state_q <= ST_DONE;
                        done_q  <= gnt_mask_d;
                        err_q   <= gnt_mask_d;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    rr_last_q <= gnt_q;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fr_rd   = fr_rd_q;
    assign fr_addr = fr_addr_q;
    assign busy    = busy_q;
    assign done0   = done_q[0];
    assign done1   = done_q[1];
`ifdef XIP_FILL_ARB_TIMEOUT_EN
    assign err0    = err_q[0];
    assign err1    = err_q[1];
`else
    assign err0    = 1'b0;
    assign err1    = 1'b0;
`endif

endmodule
